processor_fetch_queue: RTL and testbench

//  Next-generation instruction fetch stage with a prefetch queue. It keeps

---
 rtl/processor_fetch_queue.sv | 156 +++++++++++++++
 tb/tb_processor_fetch_queue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/processor_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : processor_fetch_queue
// Description : Instruction fetch stage with a prefetch queue. It reads
//               ahead from synchronous code memory and buffers up to DEPTH
//               {ip, word} pairs for decode. A redirect (call/jump) flushes
//               the queue, drops any in-flight read and restarts fetch at
//               the new target.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock          in   1              rising-edge clock
//   reset          in   1              asynchronous, active-high reset
//   call_performed in   1              redirect request
//   ip_to_call     in   ADDR_SIZE      redirect target
//   code_addr      out  ADDR_SIZE      code memory read address (fetch ip)
//   code_rd        out  1              code memory read strobe
//   code_word      in   WORD_SIZE      code memory data, 1 cycle after code_rd
//   out_valid      out  1              queue head valid
//   out_ready      in   1              decode accepts head
//   ip_out         out  ADDR_SIZE      address of head word
//   code_word_out  out  WORD_SIZE      head instruction word
//   fill_level     out  clog2(DEPTH)+1 entries currently queued
// ============================================================================
module processor_fetch_queue #(
  parameter int                      ADDR_SIZE = 18,
  parameter int                      WORD_SIZE = 18,
  parameter int                      DEPTH     = 4,
  parameter logic [ADDR_SIZE-1:0]    RESET_IP  = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       call_performed,
  input  logic [ADDR_SIZE-1:0]       ip_to_call,
  output logic [ADDR_SIZE-1:0]       code_addr,
  output logic                       code_rd,
  input  logic [WORD_SIZE-1:0]       code_word,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_SIZE-1:0]       ip_out,
  output logic [WORD_SIZE-1:0]       code_word_out,
  output logic [$clog2(DEPTH):0]     fill_level
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W:0]   c_LIMIT  = (c_CNT_W + 1)'(DEPTH);

  // Fetch pointer and the single outstanding memory read
  logic [ADDR_SIZE-1:0] r_ip;
  logic                 r_inflight;
  logic [ADDR_SIZE-1:0] r_inflight_addr;

  // Queue storage (circular buffer) and bookkeeping
  logic [ADDR_SIZE-1:0] r_q_ip   [DEPTH];
  logic [WORD_SIZE-1:0] r_q_word [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;

  // Last head seen while valid; shown on the outputs when the queue is empty
  logic [ADDR_SIZE-1:0] r_last_ip;
  logic [WORD_SIZE-1:0] r_last_word;

  logic                 w_valid;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_issue;
  logic [c_CNT_W:0]     w_credit;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & out_ready;
  // A redirect drops the returning word instead of queueing it
  assign w_push  = r_inflight & ~call_performed;

  // Occupancy seen by a new read: queued + outstanding, minus the entry
  // being popped this cycle. Counting the pop as a credit lets a 2-deep
  // queue sustain one word per cycle.
  assign w_credit = {1'b0, r_count}
                  + (c_CNT_W + 1)'(r_inflight)
                  - (c_CNT_W + 1)'(w_pop);

  // Reset is folded in so the read strobe is low while reset is held
  assign w_issue = ~reset & ~call_performed & (w_credit < c_LIMIT);

  assign code_rd       = w_issue;
  assign code_addr     = r_ip;
  assign out_valid     = w_valid;
  assign fill_level    = r_count;
  assign ip_out        = w_valid ? r_q_ip[r_rd_ptr]   : r_last_ip;
  assign code_word_out = w_valid ? r_q_word[r_rd_ptr] : r_last_word;

  // Fetch pointer, in-flight tracking and queue pointers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ip            <= RESET_IP;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
    end else if (call_performed) begin
      r_ip       <= ip_to_call;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_issue) begin
        r_inflight      <= 1'b1;
        r_inflight_addr <= r_ip;
        r_ip            <= r_ip + ADDR_SIZE'(1);
      end else begin
        r_inflight <= 1'b0;
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end

      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CNT_W'(1);
      end

      // The issue credit must never let a word arrive at a full queue
      assert (!(w_push && !w_pop && (r_count == c_FULL)));
    end
  end

  // Queue storage needs no reset: entries are only visible while counted
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_ip[r_wr_ptr]   <= r_inflight_addr;
      r_q_word[r_wr_ptr] <= code_word;
    end
  end

  // Hold the most recent head so outputs stay stable while the queue is empty
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_ip   <= '0;
      r_last_word <= '0;
    end else if (w_valid) begin
      r_last_ip   <= r_q_ip[r_rd_ptr];
      r_last_word <= r_q_word[r_rd_ptr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_processor_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_processor_fetch_queue
// Description : Directed self-checking bench for processor_fetch_queue with a
//               scoreboard of expected {ip, word} pairs per fetch epoch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_processor_fetch_queue;

  localparam int          c_AW   = 18;
  localparam int          c_WW   = 18;
  localparam int          c_DEP  = 4;
  localparam logic [17:0] c_XOR  = 18'h2AAAA;

  logic              clock;
  logic              reset;
  logic              call_performed;
  logic [c_AW-1:0]   ip_to_call;
  logic [c_AW-1:0]   code_addr;
  logic              code_rd;
  logic [c_WW-1:0]   code_word;
  logic              out_valid;
  logic              out_ready;
  logic [c_AW-1:0]   ip_out;
  logic [c_WW-1:0]   code_word_out;
  logic [2:0]        fill_level;

  int checks   = 0;
  int failures = 0;

  logic [35:0] sb[$];

  processor_fetch_queue #(
    .ADDR_SIZE (c_AW),
    .WORD_SIZE (c_WW),
    .DEPTH     (c_DEP),
    .RESET_IP  (18'h0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .call_performed (call_performed),
    .ip_to_call     (ip_to_call),
    .code_addr      (code_addr),
    .code_rd        (code_rd),
    .code_word      (code_word),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .ip_out         (ip_out),
    .code_word_out  (code_word_out),
    .fill_level     (fill_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous code memory: word = addr ^ 0x2AAAA, one cycle latency
  initial code_word = '0;
  always @(posedge clock) begin
    if (code_rd) code_word <= code_addr ^ c_XOR;
  end

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start a new epoch: the stream must run target, target+1, ... modulo 2^18
  task automatic sb_load(input logic [c_AW-1:0] start);
    logic [c_AW-1:0] a;
    sb.delete();
    for (int i = 0; i < 64; i++) begin
      a = start + c_AW'(i);
      sb.push_back({a, a ^ c_XOR});
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  // Every accepted head (except one discarded by a concurrent redirect)
  // must be the next expected entry of the current epoch
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready && !call_performed) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 36'(sb.size()), 36'd1);
      end else begin
        check("stream", {ip_out, code_word_out}, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    call_performed = 1'b0;
    ip_to_call     = '0;
    out_ready      = 1'b1;

    // 1: reset state, first word 2 cycles after release, steady stream
    cyc(); cyc();
    check("rst_code_rd",   36'(code_rd),       36'd0);
    check("rst_out_valid", 36'(out_valid),     36'd0);
    check("rst_fill",      36'(fill_level),    36'd0);
    check("rst_ip_out",    36'(ip_out),        36'd0);
    check("rst_word_out",  36'(code_word_out), 36'd0);
    check("rst_code_addr", 36'(code_addr),     36'd0);
    sb_load(18'h0);
    reset = 1'b0;
    cyc();
    check("t1_valid_e1",   36'(out_valid), 36'd0);
    check("t1_code_rd_e1", 36'(code_rd),   36'd1);
    check("t1_addr_e1",    36'(code_addr), 36'd1);
    cyc();
    check("t1_valid_e2", 36'(out_valid), 36'd1);
    check("t1_head_e2",  {ip_out, code_word_out}, {18'h0, c_XOR});
    check("t1_fill_e2",  36'(fill_level), 36'd1);
    repeat (8) cyc();
    check("t1_fill_steady", 36'(fill_level), 36'd1);

    // 2: decode stall fills the queue and stops issue, then resumes in order
    out_ready = 1'b0;
    repeat (10) cyc();
    check("t2_fill_full", 36'(fill_level), 36'(c_DEP));
    check("t2_code_rd",   36'(code_rd),    36'd0);
    check("t2_valid",     36'(out_valid),  36'd1);
    out_ready = 1'b1;
    repeat (10) cyc();

    // 3: redirect while full
    out_ready = 1'b0;
    repeat (6) cyc();
    check("t3_fill_full", 36'(fill_level), 36'(c_DEP));
    call_performed = 1'b1;
    ip_to_call     = 18'h100;
    sb_load(18'h100);
    cyc();
    check("t3_valid_flush", 36'(out_valid),  36'd0);
    check("t3_fill_flush",  36'(fill_level), 36'd0);
    check("t3_rd_blocked",  36'(code_rd),    36'd0);
    call_performed = 1'b0;
    out_ready      = 1'b1;
    cyc(); cyc();
    check("t3_valid", 36'(out_valid), 36'd1);
    check("t3_head",  {ip_out, code_word_out}, {18'h100, 18'h100 ^ c_XOR});
    repeat (6) cyc();

    // 4: redirect with a pop and a returning word in the same cycle
    check("t4_pop_pending", 36'(out_valid), 36'd1);
    call_performed = 1'b1;
    ip_to_call     = 18'h200;
    sb_load(18'h200);
    cyc();
    check("t4_fill_flush",  36'(fill_level), 36'd0);
    check("t4_valid_flush", 36'(out_valid),  36'd0);
    call_performed = 1'b0;
    cyc(); cyc();
    check("t4_head", {out_valid, ip_out, code_word_out} , {1'b1, 18'h200, 18'h200 ^ c_XOR});
    repeat (4) cyc();

    // 5: address wrap
    call_performed = 1'b1;
    ip_to_call     = 18'h3FFFE;
    sb_load(18'h3FFFE);
    cyc();
    call_performed = 1'b0;
    cyc(); cyc();
    check("t5_ip0", 36'(ip_out), 36'h3FFFE);
    cyc();
    check("t5_ip1", 36'(ip_out), 36'h3FFFF);
    cyc();
    check("t5_ip2", 36'(ip_out), 36'h00000);
    cyc();
    check("t5_ip3", {ip_out, code_word_out}, {18'h00001, 18'h00001 ^ c_XOR});
    repeat (4) cyc();

    // Back-to-back redirects: the last target wins
    call_performed = 1'b1;
    ip_to_call     = 18'h050;
    sb_load(18'h050);
    cyc();
    ip_to_call = 18'h060;
    sb_load(18'h060);
    cyc();
    check("b2b_fill", 36'(fill_level), 36'd0);
    call_performed = 1'b0;
    cyc(); cyc();
    check("b2b_head", {out_valid, ip_out}, {1'b1, 18'h060});
    repeat (4) cyc();

    // 6: asynchronous reset pulse between clock edges
    #2 reset = 1'b1;
    #1;
    check("t6_valid",     36'(out_valid),     36'd0);
    check("t6_code_rd",   36'(code_rd),       36'd0);
    check("t6_fill",      36'(fill_level),    36'd0);
    check("t6_ip_out",    36'(ip_out),        36'd0);
    check("t6_word_out",  36'(code_word_out), 36'd0);
    check("t6_code_addr", 36'(code_addr),     36'd0);
    sb_load(18'h0);
    cyc();
    reset = 1'b0;
    cyc();
    check("t6_valid_e1", 36'(out_valid), 36'd0);
    cyc();
    check("t6_head", {out_valid, ip_out, code_word_out}, {1'b1, 18'h0, c_XOR});
    repeat (6) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
